// File: rtl/can_param_load_sequencer_pkg.sv
// Shared CAN parameter-load definitions: field widths, sequencer state
// encoding and the single source of truth for the 4-byte parameter frame.
package can_param_load_sequencer_pkg;

  localparam int CAN_ID_W          = 11;
  localparam int CAN_SJW_W         = 3;
  localparam int PARAM_FRAME_BYTES = 4;
  localparam int PARAM_FRAME_W     = PARAM_FRAME_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_GUARD = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [CAN_ID_W-1:0]  mask;
    logic [CAN_ID_W-1:0]  code;
    logic [CAN_SJW_W-1:0] sjw;
  } param_fields_t;

  // MSB-first packing of 25 payload bits into 32; B0 ends up in [31:24].
  function automatic logic [PARAM_FRAME_W-1:0] pack_param_frame(
    input logic [CAN_ID_W-1:0]  mask,
    input logic [CAN_ID_W-1:0]  code,
    input logic [CAN_SJW_W-1:0] sjw
  );
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    b0 = mask[10:3];
    b1 = {mask[2:0], code[10:6]};
    b2 = {code[5:0], sjw[2:1]};
    b3 = {sjw[0], 7'b0};
    return {b0, b1, b2, b3};
  endfunction

  // Inverse of pack_param_frame, for the receiving side of the frame.
  function automatic param_fields_t unpack_param_frame(
    input logic [PARAM_FRAME_W-1:0] frame
  );
    param_fields_t f;
    f.mask = frame[31:21];
    f.code = frame[20:10];
    f.sjw  = frame[9:7];
    return f;
  endfunction

endpackage

// File: rtl/can_param_load_sequencer.sv
// Host-side byte-load transmitter: snapshots mask/code/SJW on start and
// streams the packed 4-byte frame on param_ld/data_out, then holds a guard gap.
module can_param_load_sequencer
  import can_param_load_sequencer_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CAN_ID_W-1:0]  mask_in,
  input  logic [CAN_ID_W-1:0]  code_in,
  input  logic [CAN_SJW_W-1:0] sjw_in,
  output logic                 param_ld,
  output logic [7:0]           data_out,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] LAST_BYTE  = 2'(PARAM_FRAME_BYTES - 1);
  localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES - 1);

  seq_state_t               r_state;
  logic [PARAM_FRAME_W-1:0] r_shift;
  logic [1:0]               r_byte_cnt;
  logic [3:0]               r_guard_cnt;
  logic                     r_param_ld;
  logic [7:0]               r_data_out;
  logic                     r_busy;
  logic                     r_done;

  seq_state_t               w_state_nxt;
  logic [PARAM_FRAME_W-1:0] w_shift_nxt;
  logic [1:0]               w_byte_cnt_nxt;
  logic [3:0]               w_guard_cnt_nxt;
  logic                     w_param_ld_nxt;
  logic [7:0]               w_data_out_nxt;
  logic                     w_busy_nxt;
  logic                     w_done_nxt;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_guard_cnt_nxt = r_guard_cnt;
    w_done_nxt      = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt    = ST_LOAD;
          w_shift_nxt    = pack_param_frame(mask_in, code_in, sjw_in);
          w_byte_cnt_nxt = 2'd0;
        end
      end
      ST_LOAD: begin
        w_shift_nxt    = {r_shift[PARAM_FRAME_W-9:0], 8'h00};
        w_byte_cnt_nxt = r_byte_cnt + 2'd1;
        if (r_byte_cnt == LAST_BYTE) begin
          w_state_nxt     = ST_GUARD;
          w_done_nxt      = 1'b1;
          w_guard_cnt_nxt = 4'd0;
        end
      end
      ST_GUARD: begin
        if (r_guard_cnt == GUARD_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_guard_cnt_nxt = r_guard_cnt + 4'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Outputs are derived from the next state so they can be registered
    // without adding a cycle of latency.
    w_param_ld_nxt = (w_state_nxt == ST_LOAD);
    w_data_out_nxt = w_param_ld_nxt ? w_shift_nxt[PARAM_FRAME_W-1 -: 8] : 8'h00;
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_byte_cnt  <= 2'd0;
      r_guard_cnt <= 4'd0;
      r_param_ld  <= 1'b0;
      r_data_out  <= 8'h00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_guard_cnt <= w_guard_cnt_nxt;
      r_param_ld  <= w_param_ld_nxt;
      r_data_out  <= w_data_out_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign param_ld = r_param_ld;
  assign data_out = r_data_out;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_can_param_load_sequencer.sv
// Randomized self-checking bench: a timing-rule reference model predicts every
// output each cycle, and a behavioural registry rebuilds fields from the bytes.
module tb_can_param_load_sequencer;

  localparam int G = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] mask_in;
  logic [10:0] code_in;
  logic [2:0]  sjw_in;
  logic        param_ld;
  logic [7:0]  data_out;
  logic        busy;
  logic        done;

  can_param_load_sequencer #(.GUARD_CYCLES(G)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mask_in  (mask_in),
    .code_in  (code_in),
    .sjw_in   (sjw_in),
    .param_ld (param_ld),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame timing derived from the accept edge k.
  int         n = 0;
  int         k = 0;
  bit         active = 0;
  int         acc_edge = 0;
  logic [7:0] eb [4];
  logic [10:0] snap_mask;
  logic [10:0] snap_code;
  logic [2:0]  snap_sjw;

  // Behavioural registry / collector state.
  logic [7:0] q[$];
  logic [7:0] lf [4];
  bit         prev_pld = 0;
  bit         b2b_mode = 0;
  bit         had_frame = 0;
  int         low_run = 0;
  int         starts = 0;

  task automatic step(input logic s, input logic [10:0] m, input logic [10:0] c,
                      input logic [2:0] j, input logic r);
    logic [31:0] w;
    int d;
    logic e_pld, e_busy, e_done;
    logic [7:0] e_data;
    start = s; mask_in = m; code_in = c; sjw_in = j; reset = r;
    @(posedge clk);
    n++;
    if (r) begin
      active = 0;
      acc_edge = 0;
    end else if (s && n >= acc_edge) begin
      w = {m, c, j, 7'b0};
      for (int i = 0; i < 4; i++) eb[i] = w[31-8*i -: 8];
      snap_mask = m; snap_code = c; snap_sjw = j;
      active = 1;
      k = n;
      acc_edge = n + 5 + G;
    end
    d = n - k;
    e_pld  = active && d >= 0 && d <= 3;
    e_data = e_pld ? eb[d] : 8'h00;
    e_done = active && d == 4;
    e_busy = active && d >= 0 && d <= 3 + G;
    @(negedge clk);
    check("param_ld", {31'b0, param_ld}, {31'b0, e_pld});
    check("data_out", {24'b0, data_out}, {24'b0, e_data});
    check("busy", {31'b0, busy}, {31'b0, e_busy});
    check("done", {31'b0, done}, {31'b0, e_done});

    if (r) begin
      q.delete();
      prev_pld = 0;
    end else begin
      if (param_ld) begin
        if (!prev_pld) begin
          starts++;
          if (b2b_mode && had_frame) check("b2b_gap", low_run, G + 1);
          had_frame = 1;
        end
        low_run = 0;
        q.push_back(data_out);
      end else begin
        low_run++;
      end
      prev_pld = param_ld;
      if (done) begin
        check("lb_len", q.size(), 4);
        if (q.size() == 4) begin
          w = {q[0], q[1], q[2], q[3]};
          for (int i = 0; i < 4; i++) lf[i] = q[i];
          check("lb_mask", w[31:21], snap_mask);
          check("lb_code", w[20:10], snap_code);
          check("lb_sjw", w[9:7], snap_sjw);
          check("lb_pad", w[6:0], 0);
        end
        q.delete();
      end
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 11'h000, 11'h000, 3'b000, 1'b0);
  endtask

  task automatic frame(input logic [10:0] m, input logic [10:0] c, input logic [2:0] j);
    step(1'b1, m, c, j, 1'b0);
    idle(4 + G + 2);
  endtask

  initial begin
    start = 0; mask_in = 0; code_in = 0; sjw_in = 0; reset = 0;
    #1 reset = 1;
    #1;
    check("rst_param_ld", {31'b0, param_ld}, 0);
    check("rst_data_out", {24'b0, data_out}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 11'h000, 11'h000, 3'b000, 1'b1);

    // Basic frame.
    frame(11'h5A5, 11'h0F3, 3'b101);
    check("basic_b0", lf[0], 8'hB4);
    check("basic_b1", lf[1], 8'hA3);
    check("basic_b2", lf[2], 8'hCE);
    check("basic_b3", lf[3], 8'h80);

    // Extremes.
    frame(11'h7FF, 11'h7FF, 3'b111);
    check("ones_b0", lf[0], 8'hFF);
    check("ones_b2", lf[2], 8'hFF);
    check("ones_b3", lf[3], 8'h80);
    starts = 0;
    frame(11'h000, 11'h000, 3'b000);
    check("zeros_b3", lf[3], 8'h00);
    check("zeros_starts", starts, 1);

    // Snapshot isolation: input churn and start pulses during LOAD and the
    // final guard cycle must not disturb the frame or start another one.
    starts = 0;
    step(1'b1, 11'h123, 11'h456, 3'b011, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 11'($urandom), 11'($urandom), 3'($urandom), 1'b0);
    step(1'b0, 11'h7FF, 11'h7FF, 3'b111, 1'b0);
    step(1'b0, 11'h7FF, 11'h7FF, 3'b111, 1'b0);
    step(1'b1, 11'h7FF, 11'h7FF, 3'b111, 1'b0);
    idle(4);
    check("snap_b0", lf[0], 8'h24);
    check("snap_starts", starts, 1);

    // Back-to-back with start held high.
    starts = 0; b2b_mode = 1; had_frame = 0; low_run = 0;
    for (int i = 0; i < 20; i++)
      step(1'b1, 11'($urandom), 11'($urandom), 3'($urandom), 1'b0);
    b2b_mode = 0;
    idle(8);
    check("b2b_frames", starts, 3);

    // Asynchronous reset between edges, right after B1 is on the bus.
    step(1'b1, 11'h3C3, 11'h1A5, 3'b110, 1'b0);
    idle(1);
    #2 reset = 1;
    #1;
    check("amid_param_ld", {31'b0, param_ld}, 0);
    check("amid_data_out", {24'b0, data_out}, 0);
    check("amid_busy", {31'b0, busy}, 0);
    check("amid_done", {31'b0, done}, 0);
    step(1'b0, 11'h000, 11'h000, 3'b000, 1'b1);
    step(1'b0, 11'h000, 11'h000, 3'b000, 1'b1);
    starts = 0;
    frame(11'h2DB, 11'h64A, 3'b001);
    check("post_rst_starts", starts, 1);
    check("post_rst_b0", lf[0], 8'h5B);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) == 0, 11'($urandom), 11'($urandom), 3'($urandom),
           $urandom_range(0, 99) == 0);
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
